cnt_seq_ctrl: RTL and testbench

Sequencing controller for an N-bit up/down counter datapath. It owns the count register and drives its enable and direction from a small FSM. Supported run modes are one-shot, auto-reload and ping-pong (up then down). It emits a terminal-count pulse and status for a host or a downstream timer consumer.

---
 rtl/cnt_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// Sequencing controller for an N-bit up/down counter: one-shot, auto-reload and ping-pong runs.
// Optional step prescaler enabled by defining PRESCALE_EN (adds PRE_W parameter and prescale port).
module cnt_seq_ctrl #(
  parameter int unsigned N = 8
`ifdef PRESCALE_EN
  , parameter int unsigned PRE_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     limit,
`ifdef PRESCALE_EN
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic [N-1:0]     count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN, DONE} state_t;

  localparam logic [1:0] MODE_RELOAD = 2'd1;
  localparam logic [1:0] MODE_PING   = 2'd2;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_count, w_count_nxt;
  logic [N-1:0]   r_limit, w_limit_nxt;
  logic [1:0]     r_mode, w_mode_nxt;
  logic           r_dir, w_dir_nxt;
  logic           r_busy, r_done, r_tc, w_tc_nxt;
  logic           w_step;
  logic           w_load;
  logic           w_clr_pre;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_count <= '0;
      r_limit <= '0;
      r_mode  <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_limit <= w_limit_nxt;
      r_mode  <= w_mode_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= (w_state_nxt == RUN_UP) || (w_state_nxt == RUN_DOWN);
      r_done  <= (w_state_nxt == DONE);
      r_tc    <= w_tc_nxt;
    end
  end

  // Next-state and datapath update; stop outranks start and terminal events
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_limit_nxt = r_limit;
    w_mode_nxt  = r_mode;
    w_dir_nxt   = r_dir;
    w_tc_nxt    = 1'b0;
    w_load      = 1'b0;
    w_clr_pre   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_clr_pre   = 1'b1;
        end else if (start) begin
          w_mode_nxt  = mode;
          w_limit_nxt = limit;
          w_count_nxt = '0;
          w_dir_nxt   = 1'b0;
          w_state_nxt = RUN_UP;
          w_load      = 1'b1;
          w_clr_pre   = 1'b1;
        end
      end
      RUN_UP: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_clr_pre   = 1'b1;
        end else if (w_step) begin
          if (r_count == r_limit) begin
            w_tc_nxt = 1'b1;
            case (r_mode)
              MODE_RELOAD: w_count_nxt = '0;
              MODE_PING: begin
                // a zero limit has nowhere to turn, so it parks at zero
                if (r_limit != '0) begin
                  w_count_nxt = r_limit - N'(1);
                  w_dir_nxt   = 1'b1;
                  w_state_nxt = RUN_DOWN;
                end
              end
              default: w_state_nxt = DONE;
            endcase
          end else begin
            w_count_nxt = r_count + N'(1);
          end
        end
      end
      RUN_DOWN: begin
        if (stop) begin
          w_state_nxt = IDLE;
          w_clr_pre   = 1'b1;
        end else if (w_step) begin
          if (r_count == '0) begin
            w_tc_nxt    = 1'b1;
            w_count_nxt = N'(1);
            w_dir_nxt   = 1'b0;
            w_state_nxt = RUN_UP;
          end else begin
            w_count_nxt = r_count - N'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef PRESCALE_EN
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] r_pre_lat;

  assign w_step = (r_pre == r_pre_lat);

  // Step divider: one step every r_pre_lat+1 cycles while running
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pre     <= '0;
      r_pre_lat <= '0;
    end else begin
      if (w_load) r_pre_lat <= prescale;
      if (w_clr_pre) r_pre <= '0;
      else if ((r_state == RUN_UP) || (r_state == RUN_DOWN))
        r_pre <= w_step ? '0 : r_pre + PRE_W'(1);
    end
  end
`else
  logic w_unused_pre;
  assign w_unused_pre = w_load ^ w_clr_pre;
  assign w_step       = 1'b1;
`endif

  assign count    = r_count;
  assign dir      = r_dir;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tc_pulse = r_tc;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed self-checking bench for cnt_seq_ctrl; prescaler scenario builds only with PRESCALE_EN.
module tb_cnt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] limit;
`ifdef PRESCALE_EN
  logic [3:0] prescale;
`endif
  logic [7:0] count;
  logic       dir;
  logic       busy;
  logic       done;
  logic       tc_pulse;

  int checks = 0;
  int errors = 0;

  // Ping-pong limit=3, values after edges T+0..T+13
  logic [7:0] pp_cnt [0:13] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0,
                                8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
  logic       pp_dir [0:13] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  logic       pp_tc  [0:13] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  cnt_seq_ctrl #(.N(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .limit    (limit),
`ifdef PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .tc_pulse (tc_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] l);
    mode  = m;
    limit = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({count, dir, busy, done, tc_pulse} !== 12'h000) begin
      errors++;
      $display("FAIL reset_init got count=%0d dir=%b busy=%b done=%b tc=%b want all 0",
               count, dir, busy, done, tc_pulse);
    end
    do_start(2'd1, 8'd5);
    step(); step(); step();
    checks++;
    if (count !== 8'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun got count=%0d busy=%b want 3/1", count, busy);
    end
    rstn = 1'b0;
    step(); step();
    checks++;
    if ({count, dir, busy, done, tc_pulse} !== 12'h000) begin
      errors++;
      $display("FAIL reset_midrun got count=%0d dir=%b busy=%b done=%b tc=%b want all 0",
               count, dir, busy, done, tc_pulse);
    end
    rstn = 1'b1;
    step(); step();
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got count=%0d busy=%b tc=%b want 0/0/0", count, busy, tc_pulse);
    end
  endtask

  task automatic test_oneshot();
    int pulses;
    pulses = 0;
    do_start(2'd0, 8'd3);
    checks++;
    if (count !== 8'd0 || busy !== 1'b1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL os_start got count=%0d busy=%b dir=%b want 0/1/0", count, busy, dir);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (count !== 8'(k) || busy !== 1'b1 || done !== 1'b0 || tc_pulse !== 1'b0) begin
        errors++;
        $display("FAIL os_count k=%0d got count=%0d busy=%b done=%b tc=%b want %0d/1/0/0",
                 k, count, busy, done, tc_pulse, k);
      end
    end
    step();
    if (tc_pulse === 1'b1) pulses++;
    checks++;
    if (count !== 8'd3 || busy !== 1'b0 || done !== 1'b1 || tc_pulse !== 1'b1) begin
      errors++;
      $display("FAIL os_done got count=%0d busy=%b done=%b tc=%b want 3/0/1/1",
               count, busy, done, tc_pulse);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (tc_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || count !== 8'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL os_hold got pulses=%0d count=%0d done=%b want 1/3/1", pulses, count, done);
    end
    do_start(2'd0, 8'd3);
    step();
    checks++;
    if (count !== 8'd1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL os_restart got count=%0d busy=%b done=%b want 1/1/0", count, busy, done);
    end
    do_stop();
    // reserved mode behaves as one-shot
    do_start(2'd3, 8'd1);
    step(); step();
    checks++;
    if (count !== 8'd1 || done !== 1'b1 || busy !== 1'b0 || tc_pulse !== 1'b1) begin
      errors++;
      $display("FAIL os_mode3 got count=%0d done=%b busy=%b tc=%b want 1/1/0/1",
               count, done, busy, tc_pulse);
    end
    do_stop();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL os_stop_done got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_reload();
    int pulses;
    pulses = 0;
    do_start(2'd1, 8'd2);
    for (int k = 1; k <= 12; k++) begin
      start = (k == 5 || k == 9);
      mode  = 2'd0;
      limit = 8'd7;
      step();
      start = 1'b0;
      if (tc_pulse === 1'b1) pulses++;
      checks++;
      if (count !== 8'(k % 3) || tc_pulse !== (k % 3 == 0) || busy !== 1'b1) begin
        errors++;
        $display("FAIL reload k=%0d got count=%0d tc=%b busy=%b want %0d/%b/1",
                 k, count, tc_pulse, busy, k % 3, (k % 3 == 0));
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL reload_pulses got %0d want 4", pulses);
    end
    do_stop();
  endtask

  task automatic test_pingpong();
    do_start(2'd2, 8'd3);
    for (int k = 1; k <= 13; k++) begin
      step();
      checks++;
      if (count !== pp_cnt[k] || dir !== pp_dir[k] || tc_pulse !== pp_tc[k]) begin
        errors++;
        $display("FAIL pingpong k=%0d got count=%0d dir=%b tc=%b want %0d/%b/%b",
                 k, count, dir, tc_pulse, pp_cnt[k], pp_dir[k], pp_tc[k]);
      end
    end
    do_stop();
    do_start(2'd2, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (count !== 8'd0 || dir !== 1'b0 || tc_pulse !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pp_zero k=%0d got count=%0d dir=%b tc=%b busy=%b want 0/0/1/1",
                 k, count, dir, tc_pulse, busy);
      end
    end
    do_stop();
    do_start(2'd1, 8'd0);
    step(); step();
    checks++;
    if (count !== 8'd0 || tc_pulse !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_zero got count=%0d tc=%b busy=%b want 0/1/1", count, tc_pulse, busy);
    end
    do_stop();
  endtask

  task automatic test_stop();
    do_start(2'd1, 8'd9);
    step(); step(); step(); step();
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    checks++;
    if (count !== 8'd4 || busy !== 1'b0 || done !== 1'b0 || tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL stop_start got count=%0d busy=%b done=%b tc=%b want 4/0/0/0",
               count, busy, done, tc_pulse);
    end
    step();
    checks++;
    if (count !== 8'd4 || busy !== 1'b0 || tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold got count=%0d busy=%b tc=%b want 4/0/0", count, busy, tc_pulse);
    end
    do_start(2'd0, 8'd2);
    step(); step();
    do_stop();
    checks++;
    if (count !== 8'd2 || done !== 1'b0 || busy !== 1'b0 || tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL stop_term got count=%0d done=%b busy=%b tc=%b want 2/0/0/0",
               count, done, busy, tc_pulse);
    end
    step();
    checks++;
    if (done !== 1'b0 || tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL stop_term_after got done=%b tc=%b want 0/0", done, tc_pulse);
    end
    // ping-pong stopped while counting down keeps its direction
    do_start(2'd2, 8'd3);
    for (int k = 0; k < 5; k++) step();
    do_stop();
    checks++;
    if (count !== 8'd1 || dir !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_down got count=%0d dir=%b busy=%b want 1/1/0", count, dir, busy);
    end
  endtask

  task automatic test_max();
    do_start(2'd0, 8'd255);
    for (int k = 0; k < 255; k++) step();
    checks++;
    if (count !== 8'd255 || busy !== 1'b1 || tc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL max_top got count=%0d busy=%b tc=%b want 255/1/0", count, busy, tc_pulse);
    end
    step();
    checks++;
    if (count !== 8'd255 || done !== 1'b1 || tc_pulse !== 1'b1) begin
      errors++;
      $display("FAIL max_done got count=%0d done=%b tc=%b want 255/1/1", count, done, tc_pulse);
    end
    do_stop();
  endtask

`ifdef PRESCALE_EN
  task automatic test_prescale();
    logic [7:0] exp_c;
    prescale = 4'd2;
    do_start(2'd0, 8'd2);
    prescale = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_c = (k >= 6) ? 8'd2 : ((k >= 3) ? 8'd1 : 8'd0);
      checks++;
      if (count !== exp_c || tc_pulse !== (k == 9) || done !== (k >= 9)) begin
        errors++;
        $display("FAIL prescale k=%0d got count=%0d tc=%b done=%b want %0d/%b/%b",
                 k, count, tc_pulse, done, exp_c, (k == 9), (k >= 9));
      end
    end
    do_stop();
    prescale = 4'd2;
    do_start(2'd1, 8'd5);
    step(); step();
    do_stop();
    do_start(2'd1, 8'd5);
    step(); step();
    checks++;
    if (count !== 8'd0) begin
      errors++;
      $display("FAIL pre_clr_a got count=%0d want 0", count);
    end
    step();
    checks++;
    if (count !== 8'd1) begin
      errors++;
      $display("FAIL pre_clr_b got count=%0d want 1", count);
    end
    do_stop();
  endtask
`endif

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 2'd0;
    limit = 8'd0;
`ifdef PRESCALE_EN
    prescale = 4'd0;
`endif
    step(); step();
    rstn = 1'b1;
    step();
    test_reset();
    test_oneshot();
    test_reload();
    test_pingpong();
    test_stop();
    test_max();
`ifdef PRESCALE_EN
    test_prescale();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
